// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned WIDTH_DEF = 16;

    // Iteration counter width: must be able to hold the value `w`.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_control.sv
// Divider sequencer: accepts start, runs `width` iterations, flags completion.
module div_control
    import divider_pkg::*;
#(
    parameter int unsigned width = WIDTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic divisor_zero,
    output logic load,
    output logic step,
    output logic finish,
    output logic zero_finish,
    output logic done,
    output logic busy
);

    localparam int unsigned    CNT_W = cnt_width(width);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(width - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // Next-state, counter and datapath strobes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;
        zero_finish = 1'b0;
        accept      = start && (state_q != RUN);
        case (state_q)
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            IDLE, DONE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (divisor_zero) begin
                        zero_finish = 1'b1;
                        state_d     = DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done = (state_q == DONE);
    assign busy = (state_q == RUN);

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
module divider
    import divider_pkg::*;
#(
    parameter int unsigned width = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int unsigned EW = width + 1;

    logic             load, step, finish, zero_finish;
    logic [width-1:0] dvd_q, dvd_d;
    logic [width-1:0] dvs_q, dvs_d;
    logic [width-1:0] rem_q, rem_d;
    logic [width-1:0] q_q, q_d;
    logic [width-1:0] quo_q, quo_d;
    logic [width-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;
    logic [EW-1:0]    trial, diff;
    logic             ge;
    logic [width-1:0] rem_nxt, q_nxt;

    div_control #(.width(width)) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .divisor_zero(B == '0),
        .load        (load),
        .step        (step),
        .finish      (finish),
        .zero_finish (zero_finish),
        .done        (done),
        .busy        (busy)
    );

    // One restoring iteration: shift in the next dividend bit, trial-subtract.
    always_comb begin
        trial   = {rem_q, dvd_q[width-1]};
        ge      = (trial >= {1'b0, dvs_q});
        diff    = trial - {1'b0, dvs_q};
        rem_nxt = ge ? width'(diff) : width'(trial);
        q_nxt   = (q_q << 1) | width'(ge);
    end

    // Working-register and result-register updates.
    always_comb begin
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        q_d   = q_q;
        quo_d = quo_q;
        rmd_d = rmd_q;
        dbz_d = dbz_q;
        if (load) begin
            dvd_d = A;
            dvs_d = B;
            rem_d = '0;
            q_d   = '0;
        end else if (step) begin
            dvd_d = dvd_q << 1;
            rem_d = rem_nxt;
            q_d   = q_nxt;
        end
        if (finish) begin
            quo_d = q_nxt;
            rmd_d = rem_nxt;
            dbz_d = 1'b0;
        end else if (zero_finish) begin
            quo_d = '1;
            rmd_d = A;
            dbz_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            q_q   <= '0;
            quo_q <= '0;
            rmd_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            q_q   <= q_d;
            quo_q <= quo_d;
            rmd_q <= rmd_d;
            dbz_q <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule
